// File: rtl/tc_pkg.sv
// Shared definitions for the thermocouple scanner: FSM states, field widths,
// frame bit positions and the interval-counter width helper.
package tc_pkg;

  typedef enum logic [2:0] {
    ST_STARTUP = 3'd0,
    ST_REQ     = 3'd1,
    ST_ACK     = 3'd2,
    ST_XFER    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_GAP     = 3'd5
  } tc_state_e;

  localparam int TC_W  = 14;
  localparam int JT_W  = 12;
  localparam int FLT_W = 4;

  localparam int TC_MSB     = 31;
  localparam int TC_LSB     = 18;
  localparam int FLT_HI_BIT = 16;
  localparam int JT_MSB     = 15;
  localparam int JT_LSB     = 4;
  localparam int FLT_LO_MSB = 2;

  // Wide enough for the longest interval (startup, gap or ACK timeout) plus one.
  function automatic int tc_cnt_width(input int clk_freq, input int startup_s,
                                      input int period_s, input int timeout_cyc);
    int longest;
    longest = clk_freq * ((startup_s > period_s) ? startup_s : period_s);
    if (timeout_cyc > longest) longest = timeout_cyc;
    return (longest < 1) ? 1 : $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/tc_interval_timer.sv
// Saturating interval counter: cleared by load, advances while count_i is high,
// done_o once limit_i cycles have elapsed.
module tc_interval_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         count_i,
  input  logic [W-1:0] limit_i,
  output logic         done_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign done_o = (({1'b0, count_q} + {{W{1'b0}}, 1'b1}) >= {1'b0, limit_i});

  // Next count: clear on load, otherwise step until done and then hold.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (count_i && !done_o) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/thermocouple_scanner.sv
// Round-robin thermocouple SPI scanner with per-channel result registers.
// Define TC_FAULT_STICKY_EN to make fault bits sticky until fault_clr.
module thermocouple_scanner
  import tc_pkg::*;
#(
  parameter int CLK_FREQ    = 12000,
  parameter int NUM_CH      = 4,
  parameter int STARTUP_S   = 3,
  parameter int PERIOD_S    = 1,
  parameter int TIMEOUT_CYC = 64,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    spi_busy,
  input  logic [31:0]             spi_rx_data,
  input  logic                    fault_clr,
  output logic                    spi_start,
  output logic [CH_W-1:0]         spi_ch,
  output logic [TC_W*NUM_CH-1:0]  tc_temp_data,
  output logic [JT_W*NUM_CH-1:0]  junction_temp_data,
  output logic [FLT_W*NUM_CH-1:0] fault_bits,
  output logic                    sample_valid,
  output logic [CH_W-1:0]         sample_ch,
  output logic                    any_fault
);

  localparam int CNT_W = tc_cnt_width(CLK_FREQ, STARTUP_S, PERIOD_S, TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] STARTUP_LIM = CNT_W'(CLK_FREQ * STARTUP_S);
  localparam logic [CNT_W-1:0] PERIOD_LIM  = CNT_W'(CLK_FREQ * PERIOD_S);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);
  localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(NUM_CH - 1);

  tc_state_e state_q, state_d;
  logic [CH_W-1:0]         ch_q, ch_d, ch_nxt_s;
  logic                    spi_start_q, spi_start_d;
  logic                    sample_valid_q, sample_valid_d;
  logic [CH_W-1:0]         sample_ch_q, sample_ch_d;
  logic [TC_W*NUM_CH-1:0]  tc_q, tc_d;
  logic [JT_W*NUM_CH-1:0]  jt_q, jt_d;
  logic [FLT_W*NUM_CH-1:0] flt_q, flt_d;
  logic                    any_fault_q;
  logic                    timer_done_s, timer_load_s, timer_count_s;
  logic [CNT_W-1:0]        timer_limit_s;
  logic [FLT_W-1:0]        rx_flt_s;
  logic                    unused_rx_s;

  assign rx_flt_s    = {spi_rx_data[FLT_HI_BIT], spi_rx_data[FLT_LO_MSB:0]};
  assign unused_rx_s = ^{spi_rx_data[17], spi_rx_data[3]};
  assign ch_nxt_s    = (ch_q == LAST_CH) ? {CH_W{1'b0}} : ch_q + {{(CH_W-1){1'b0}}, 1'b1};

  // Every state change restarts the shared interval counter.
  assign timer_load_s  = (state_d != state_q);
  assign timer_count_s = (state_q == ST_STARTUP) || (state_q == ST_GAP) || (state_q == ST_ACK);
  assign timer_limit_s = (state_q == ST_STARTUP) ? STARTUP_LIM :
                         (state_q == ST_GAP)     ? PERIOD_LIM  : TIMEOUT_LIM;

  tc_interval_timer #(.W(CNT_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (timer_load_s),
    .count_i (timer_count_s),
    .limit_i (timer_limit_s),
    .done_o  (timer_done_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_STARTUP;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STARTUP: if (timer_done_s) state_d = ST_REQ; else state_d = ST_STARTUP;
      ST_REQ:     if (!spi_busy) state_d = ST_ACK; else state_d = ST_REQ;
      ST_ACK: begin
        if (spi_busy)          state_d = ST_XFER;
        else if (timer_done_s) state_d = (ch_q == LAST_CH) ? ST_GAP : ST_REQ;
        else                   state_d = ST_ACK;
      end
      ST_XFER:    if (!spi_busy) state_d = ST_CAPTURE; else state_d = ST_XFER;
      ST_CAPTURE: state_d = (ch_q == LAST_CH) ? ST_GAP : ST_REQ;
      ST_GAP:     if (timer_done_s) state_d = ST_REQ; else state_d = ST_GAP;
      default:    state_d = ST_REQ;
    endcase
  end

  // Output and datapath next values; a same-cycle capture lands after a clear.
  always_comb begin
    ch_d           = ch_q;
    spi_start_d    = 1'b0;
    sample_valid_d = 1'b0;
    sample_ch_d    = sample_ch_q;
    tc_d           = tc_q;
    jt_d           = jt_q;
    flt_d          = flt_q;
`ifdef TC_FAULT_STICKY_EN
    if (fault_clr) flt_d = '0;
    else           flt_d = flt_q;
`endif
    case (state_q)
      ST_STARTUP: ch_d = {CH_W{1'b0}};
      ST_REQ: begin
        if (!spi_busy) spi_start_d = 1'b1;
        else           spi_start_d = 1'b0;
      end
      ST_ACK: begin
        if (!spi_busy && timer_done_s) begin
          flt_d[int'(ch_q)*FLT_W +: FLT_W] = {FLT_W{1'b1}};
          ch_d = ch_nxt_s;
        end else begin
          ch_d = ch_q;
        end
      end
      ST_CAPTURE: begin
        tc_d[int'(ch_q)*TC_W +: TC_W] = spi_rx_data[TC_MSB:TC_LSB];
        jt_d[int'(ch_q)*JT_W +: JT_W] = spi_rx_data[JT_MSB:JT_LSB];
`ifdef TC_FAULT_STICKY_EN
        flt_d[int'(ch_q)*FLT_W +: FLT_W] = flt_d[int'(ch_q)*FLT_W +: FLT_W] | rx_flt_s;
`else
        flt_d[int'(ch_q)*FLT_W +: FLT_W] = rx_flt_s;
`endif
        sample_valid_d = 1'b1;
        sample_ch_d    = ch_q;
        ch_d           = ch_nxt_s;
      end
      default: ch_d = ch_q;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q           <= '0;
      spi_start_q    <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
      tc_q           <= '0;
      jt_q           <= '0;
      flt_q          <= '0;
      any_fault_q    <= 1'b0;
    end else begin
      ch_q           <= ch_d;
      spi_start_q    <= spi_start_d;
      sample_valid_q <= sample_valid_d;
      sample_ch_q    <= sample_ch_d;
      tc_q           <= tc_d;
      jt_q           <= jt_d;
      flt_q          <= flt_d;
      any_fault_q    <= |flt_q;
    end
  end

  assign spi_start          = spi_start_q;
  assign spi_ch             = ch_q;
  assign tc_temp_data       = tc_q;
  assign junction_temp_data = jt_q;
  assign fault_bits         = flt_q;
  assign sample_valid       = sample_valid_q;
  assign sample_ch          = sample_ch_q;
  assign any_fault          = any_fault_q;

endmodule
